cheese_collect_ctl: RTL and testbench

- Upstream controller for the cheese spawner. It watches Jerry's position against the two spawned cheese positions and decides when each cheese is eaten.
- It hides an eaten cheese, waits a respawn delay counted in frames, then pulses the spawner's 2-bit request so a fresh position is generated.
- It also keeps the collected-cheese score and flags the win condition for the game FSM and renderer.

---
 rtl/cheese_collect_ctl_pkg.sv | 11 +
 rtl/cheese_collect_ctl_slot.sv | 68 ++++++
 rtl/cheese_collect_ctl.sv | 54 +++++
 tb/tb_cheese_collect_ctl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cheese_collect_ctl_pkg.sv
// cheese_collect_ctl_pkg: shared geometry, timing constants and slot state type for the cheese collector
package cheese_collect_ctl_pkg;
  localparam int POS_W = 10;
  localparam int CHEESE_W = 20;
  localparam int CHEESE_H = 20;
  localparam int JERRY_W = 32;
  localparam int JERRY_H = 32;
  localparam int RESPAWN_FRAMES = 60;
  localparam int WIN_SCORE = 20;
  typedef enum logic [2:0] {INIT, VISIBLE, HIDDEN, REQ, SETTLE} slot_state_t;
endpackage

// File: rtl/cheese_collect_ctl_slot.sv
// cheese_slot: one cheese lifecycle (visible/eaten/respawn wait/request/settle); ports: clk, rst_n, frame_tick, frozen, grant, jerry/cheese x/y in; req, collected, vis out
module cheese_slot import cheese_collect_ctl_pkg::*; #(
  parameter int RESPAWN_FRAMES = cheese_collect_ctl_pkg::RESPAWN_FRAMES,
  parameter int CHEESE_W = cheese_collect_ctl_pkg::CHEESE_W,
  parameter int CHEESE_H = cheese_collect_ctl_pkg::CHEESE_H,
  parameter int JERRY_W = cheese_collect_ctl_pkg::JERRY_W,
  parameter int JERRY_H = cheese_collect_ctl_pkg::JERRY_H
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             frozen,
  input  logic             grant,
  input  logic [POS_W-1:0] jx,
  input  logic [POS_W-1:0] jy,
  input  logic [POS_W-1:0] cx,
  input  logic [POS_W-1:0] cy,
  output logic             req,
  output logic             collected,
  output logic             vis
);
  localparam int PW = POS_W + 1;
  slot_state_t state, state_next;
  logic [7:0] cnt, cnt_next;
  logic overlap;
  // one extra bit keeps position + size from wrapping at the screen edge
  assign overlap = (PW'(jx) < PW'(cx) + PW'(CHEESE_W)) && (PW'(cx) < PW'(jx) + PW'(JERRY_W)) &&
                   (PW'(jy) < PW'(cy) + PW'(CHEESE_H)) && (PW'(cy) < PW'(jy) + PW'(JERRY_H));
  assign req = state == REQ;
  assign vis = state == VISIBLE;
  assign collected = vis && overlap && !frozen;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt <= 8'd0;
    end else begin
      state <= state_next;
      cnt <= cnt_next;
    end
  end
  // once the game is won every slot holds where it is
  always_comb begin
    state_next = state;
    cnt_next = cnt;
    if (!frozen) begin
      case (state)
        INIT: state_next = frame_tick ? VISIBLE : INIT;
        VISIBLE: if (overlap) begin
          state_next = HIDDEN;
          cnt_next = 8'd0;
        end
        HIDDEN: if (frame_tick) begin
          state_next = (cnt == 8'(RESPAWN_FRAMES - 1)) ? REQ : HIDDEN;
          cnt_next = cnt + 8'd1;
        end
        REQ: if (grant) begin
          state_next = SETTLE;
          cnt_next = 8'd0;
        end
        SETTLE: begin
          state_next = (cnt == 8'd1) ? VISIBLE : SETTLE;
          cnt_next = cnt + 8'd1;
        end
        default: state_next = INIT;
      endcase
    end
  end
endmodule

// File: rtl/cheese_collect_ctl.sv
// cheese_collect_ctl: cheese collection, respawn request arbitration and score/win tracking; ports: clk, rst_n, frame_tick, jerry/cheese positions in; rnd_generate, cheese_vis, score, game_won out
module cheese_collect_ctl import cheese_collect_ctl_pkg::*; #(
  parameter int RESPAWN_FRAMES = cheese_collect_ctl_pkg::RESPAWN_FRAMES,
  parameter int WIN_SCORE = cheese_collect_ctl_pkg::WIN_SCORE,
  parameter int CHEESE_W = cheese_collect_ctl_pkg::CHEESE_W,
  parameter int CHEESE_H = cheese_collect_ctl_pkg::CHEESE_H,
  parameter int JERRY_W = cheese_collect_ctl_pkg::JERRY_W,
  parameter int JERRY_H = cheese_collect_ctl_pkg::JERRY_H
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic [POS_W-1:0] pjerry_x,
  input  logic [POS_W-1:0] pjerry_y,
  input  logic [POS_W-1:0] pcheese1_x,
  input  logic [POS_W-1:0] pcheese1_y,
  input  logic [POS_W-1:0] pcheese2_x,
  input  logic [POS_W-1:0] pcheese2_y,
  output logic [1:0]       rnd_generate,
  output logic [1:0]       cheese_vis,
  output logic [7:0]       score,
  output logic             game_won
);
  logic [1:0] req, gnt, col;
  logic [8:0] sum;
  // fixed priority: cheese 1 first, nothing once the game is won
  assign gnt = game_won ? 2'b00 : {req[1] & ~req[0], req[0]};
  assign sum = {1'b0, score} + {8'd0, col[0]} + {8'd0, col[1]};
  cheese_slot #(.RESPAWN_FRAMES(RESPAWN_FRAMES), .CHEESE_W(CHEESE_W), .CHEESE_H(CHEESE_H),
    .JERRY_W(JERRY_W), .JERRY_H(JERRY_H)) u_slot1 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .frozen(game_won), .grant(gnt[0]),
    .jx(pjerry_x), .jy(pjerry_y), .cx(pcheese1_x), .cy(pcheese1_y),
    .req(req[0]), .collected(col[0]), .vis(cheese_vis[0]));
  cheese_slot #(.RESPAWN_FRAMES(RESPAWN_FRAMES), .CHEESE_W(CHEESE_W), .CHEESE_H(CHEESE_H),
    .JERRY_W(JERRY_W), .JERRY_H(JERRY_H)) u_slot2 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .frozen(game_won), .grant(gnt[1]),
    .jx(pjerry_x), .jy(pjerry_y), .cx(pcheese2_x), .cy(pcheese2_y),
    .req(req[1]), .collected(col[1]), .vis(cheese_vis[1]));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_generate <= 2'b00;
      score <= 8'd0;
      game_won <= 1'b0;
    end else begin
      rnd_generate <= gnt;
      if (sum >= 9'(WIN_SCORE)) begin
        score <= 8'(WIN_SCORE);
        game_won <= 1'b1;
      end else begin
        score <= sum[7:0];
      end
    end
  end
endmodule

// File: tb/tb_cheese_collect_ctl.sv
// tb_cheese_collect_ctl: directed self-checking bench with a respawn-request scoreboard
module tb_cheese_collect_ctl;
  import cheese_collect_ctl_pkg::*;
  logic clk = 1'b0;
  logic rst_n, frame_tick;
  logic [POS_W-1:0] jx, jy, c1x, c1y, c2x, c2y;
  logic [1:0] rnd_generate, cheese_vis;
  logic [7:0] score;
  logic game_won;
  int passed = 0, total = 0, pulses = 0, cyc = 0;
  logic [1:0] exp_q[$];
  int pcyc[$];
  always #5 clk = ~clk;
  cheese_collect_ctl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .pjerry_x(jx), .pjerry_y(jy), .pcheese1_x(c1x), .pcheese1_y(c1y),
    .pcheese2_x(c2x), .pcheese2_y(c2y),
    .rnd_generate(rnd_generate), .cheese_vis(cheese_vis), .score(score), .game_won(game_won));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rst_n && rnd_generate !== 2'b00) begin
      if (exp_q.size() == 0) check("rnd_unexpected", {30'd0, rnd_generate}, 32'd0);
      else check("rnd_seq", {30'd0, rnd_generate}, {30'd0, exp_q.pop_front()});
      pulses++;
      pcyc.push_back(cyc);
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic ticks(input int n);
    frame_tick = 1'b1;
    step(n);
    frame_tick = 1'b0;
  endtask
  task automatic wait_pulses(input int target, input string tag);
    for (int i = 0; i < 300 && pulses < target; i++) step(1);
    check(tag, pulses, target);
  endtask
  task automatic wait_vis(input logic [1:0] exp, input string tag);
    for (int i = 0; i < 10 && cheese_vis !== exp; i++) step(1);
    check(tag, {30'd0, cheese_vis}, {30'd0, exp});
  endtask
  task automatic collect(input int x, input int y, input int exp_score, input logic [1:0] exp_vis, input string tag);
    jx = POS_W'(x);
    jy = POS_W'(y);
    step(1);
    check({tag, "_score"}, {24'd0, score}, exp_score);
    check({tag, "_vis"}, {30'd0, cheese_vis}, {30'd0, exp_vis});
    jx = '0;
    jy = '0;
  endtask
  task automatic respawn(input logic [1:0] which, input string tag);
    int base;
    base = pulses;
    if (which[0]) exp_q.push_back(2'b01);
    if (which[1]) exp_q.push_back(2'b10);
    ticks(RESPAWN_FRAMES);
    wait_pulses(base + int'(which[0]) + int'(which[1]), {tag, "_pulses"});
    wait_vis(2'b11, {tag, "_vis"});
  endtask
  initial begin
    int base;
    rst_n = 1'b0;
    frame_tick = 1'b0;
    jx = '0;
    jy = '0;
    c1x = 10'd110;
    c1y = 10'd210;
    c2x = 10'd500;
    c2y = 10'd400;
    step(3);
    rst_n = 1'b1;
    step(100);
    check("init_vis", {30'd0, cheese_vis}, 32'd0);
    check("init_score", {24'd0, score}, 32'd0);
    check("init_rnd", {30'd0, rnd_generate}, 32'd0);
    ticks(1);
    check("first_tick_vis", {30'd0, cheese_vis}, 32'd3);
    collect(100, 200, 1, 2'b10, "single");
    base = pulses;
    ticks(RESPAWN_FRAMES - 1);
    step(5);
    check("no_early_req", pulses, base);
    exp_q.push_back(2'b01);
    ticks(1);
    wait_pulses(base + 1, "single_pulse");
    step(1);
    check("pulse_one_cycle", {30'd0, rnd_generate}, 32'd0);
    wait_vis(2'b11, "single_revisible");
    c2x = 10'd130;
    c2y = 10'd215;
    collect(100, 200, 3, 2'b00, "double");
    respawn(2'b11, "double");
    check("arb_back_to_back", pcyc[pcyc.size()-1] - pcyc[pcyc.size()-2], 1);
    c2x = 10'd500;
    c2y = 10'd400;
    collect(130, 200, 3, 2'b11, "edge_touch");
    collect(129, 200, 4, 2'b10, "edge_inside");
    respawn(2'b01, "edge");
    c2x = 10'd130;
    c2y = 10'd215;
    for (int r = 0; r < 7; r++) begin
      collect(100, 200, 6 + 2 * r, 2'b00, "climb");
      check("climb_not_won", {31'd0, game_won}, 32'd0);
      respawn(2'b11, "climb");
    end
    collect(80, 190, 19, 2'b10, "at19");
    check("at19_not_won", {31'd0, game_won}, 32'd0);
    respawn(2'b01, "at19");
    collect(100, 200, WIN_SCORE, 2'b00, "saturate");
    check("won", {31'd0, game_won}, 32'd1);
    base = pulses;
    ticks(100);
    step(5);
    check("won_no_req", pulses, base);
    collect(100, 200, WIN_SCORE, 2'b00, "won_overlap");
    check("won_sticky", {31'd0, game_won}, 32'd1);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    ticks(1);
    check("rst2_vis", {30'd0, cheese_vis}, 32'd3);
    collect(80, 190, 1, 2'b10, "rst2_collect");
    base = pulses;
    ticks(RESPAWN_FRAMES);
    rst_n = 1'b0;
    #1;
    check("rst_mid_rnd", {30'd0, rnd_generate}, 32'd0);
    check("rst_mid_score", {24'd0, score}, 32'd0);
    check("rst_mid_won", {31'd0, game_won}, 32'd0);
    step(2);
    check("rst_hold_rnd", {30'd0, rnd_generate}, 32'd0);
    rst_n = 1'b1;
    step(5);
    check("rst_init_vis", {30'd0, cheese_vis}, 32'd0);
    check("rst_no_pulse", pulses, base);
    ticks(1);
    check("rst_tick_vis", {30'd0, cheese_vis}, 32'd3);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
